regfile_mp: RTL and testbench

//  Parametrised multi-port integer register file for the pipelined core; next generation of the single-write/two-read file.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_scoreboard.sv | 52 +++++
 rtl/regfile_mp.sv | 158 +++++++++++++++
 tb/tb_regfile_mp.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
//   XLEN_DEF / NREGS_DEF : default data width and register count
//   dbg_state_e          : debug access port handshake states
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef enum logic [1:0] {
    DBG_IDLE   = 2'd0,
    DBG_ACCESS = 2'd1,
    DBG_ACK    = 2'd2
  } dbg_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard.
//   clk, rst     : clock, synchronous active-high reset (clears all busy bits)
//   set_vec      : one-hot-or-zero set request (already filtered for reg 0 / range)
//   clr_vec      : registers receiving a committing core write this cycle
//   rd_addr      : NRD packed lookup addresses
//   rd_busy      : busy flag per lookup port
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREGS-1:0]  set_vec,
  input  logic [NREGS-1:0]  clr_vec,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy
);

  logic [NREGS-1:0] busy_q;
  logic [AW-1:0]    rd_a [NRD];

  for (genvar g = 0; g < NRD; g++) begin : g_rd_a
    assign rd_a[g] = rd_addr[g*AW +: AW];
  end

  // A new producer issuing in the same cycle as the old one retires keeps the bit set.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= set_vec | (busy_q & ~clr_vec);
    end
  end

  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (int'(rd_a[i]) < NREGS) begin
        rd_busy[i] = busy_q[rd_a[i]];
        // Retiring write visible to decode this cycle, same as the data bypass.
        if ((BYPASS != 0) && clr_vec[rd_a[i]] && !set_vec[rd_a[i]]) begin
          rd_busy[i] = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with busy scoreboard and debug access port.
//   clk, rst       : clock, synchronous active-high reset
//   enable_debug   : allows the debug handshake to start
//   rd_addr/rd_data: NRD combinational read ports (packed, port i = slice i)
//   rd_busy        : scoreboard busy flag for each read address
//   wr_en/wr_dest/wr_data : NWR core write ports, highest index wins on conflict
//   sb_set_en/sb_set_addr : mark a register busy at issue
//   dbg_req/dbg_we/dbg_addr/dbg_wdata : four-phase debug request
//   dbg_ack/dbg_rdata : debug acknowledge and read data
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable_debug,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_dest,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                sb_set_en,
  input  logic [AW-1:0]       sb_set_addr,
  input  logic                dbg_req,
  input  logic                dbg_we,
  input  logic [AW-1:0]       dbg_addr,
  input  logic [XLEN-1:0]     dbg_wdata,
  output logic                dbg_ack,
  output logic [XLEN-1:0]     dbg_rdata
);

  logic [XLEN-1:0]  regs_q  [NREGS];
  logic [XLEN-1:0]  core_wd [NREGS];
  logic [NREGS-1:0] core_we;
  logic [NREGS-1:0] sb_set_vec;
  logic [AW-1:0]    rd_a [NRD];
  logic [AW-1:0]    wr_a [NWR];
  dbg_state_e       state_q, state_d;
  logic             dbg_wr_fire, dbg_rd_fire;
  logic [XLEN-1:0]  dbg_rd_val;

  // A register that physically holds state: in range and not the hardwired zero.
  function automatic logic live_reg(input logic [AW-1:0] a);
    return (int'(a) < NREGS) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  for (genvar g = 0; g < NRD; g++) begin : g_rd_a
    assign rd_a[g] = rd_addr[g*AW +: AW];
  end
  for (genvar g = 0; g < NWR; g++) begin : g_wr_a
    assign wr_a[g] = wr_dest[g*AW +: AW];
  end

  // Ascending scan: a later (higher-index) port overwrites an earlier one.
  always_comb begin
    core_we = '0;
    for (int r = 0; r < NREGS; r++) core_wd[r] = '0;
    for (int p = 0; p < NWR; p++) begin
      if (wr_en[p] && live_reg(wr_a[p])) begin
        core_we[wr_a[p]] = 1'b1;
        core_wd[wr_a[p]] = wr_data[p*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    sb_set_vec = '0;
    if (sb_set_en && live_reg(sb_set_addr)) sb_set_vec[sb_set_addr] = 1'b1;
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NRD; i++) begin
      if (live_reg(rd_a[i])) begin
        if ((BYPASS != 0) && core_we[rd_a[i]]) begin
          rd_data[i*XLEN +: XLEN] = core_wd[rd_a[i]];
        end else begin
          rd_data[i*XLEN +: XLEN] = regs_q[rd_a[i]];
        end
      end
    end
  end

  assign dbg_rd_val = live_reg(dbg_addr) ? regs_q[dbg_addr] : '0;

  // Debug handshake: core writes always take precedence while in ACCESS, so a
  // debug write never collides with a core write on the storage array.
  always_comb begin
    state_d     = state_q;
    dbg_wr_fire = 1'b0;
    dbg_rd_fire = 1'b0;
    unique case (state_q)
      DBG_IDLE: begin
        if (dbg_req && enable_debug) state_d = DBG_ACCESS;
      end
      DBG_ACCESS: begin
        if (!dbg_req || !enable_debug) begin
          state_d = DBG_IDLE;
        end else if (|wr_en) begin
          state_d = DBG_ACCESS;
        end else begin
          dbg_wr_fire = dbg_we && live_reg(dbg_addr);
          dbg_rd_fire = !dbg_we;
          state_d     = DBG_ACK;
        end
      end
      DBG_ACK: begin
        if (!dbg_req) state_d = DBG_IDLE;
      end
      default: state_d = DBG_IDLE;
    endcase
  end

  assign dbg_ack = (state_q == DBG_ACK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DBG_IDLE;
      dbg_rdata <= '0;
    end else begin
      state_q <= state_d;
      if (dbg_rd_fire) dbg_rdata <= dbg_rd_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (core_we[r]) regs_q[r] <= core_wd[r];
      end
      if (dbg_wr_fire) regs_q[dbg_addr] <= dbg_wdata;
    end
  end

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .NRD    (NRD),
    .BYPASS (BYPASS)
  ) u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_vec (sb_set_vec),
    .clr_vec (core_we),
    .rd_addr (rd_addr),
    .rd_busy (rd_busy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: table of single-cycle core vectors followed
// by hand-written reset and debug handshake sequences.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic                enable_debug;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_dest;
  logic [NWR*XLEN-1:0] wr_data;
  logic                sb_set_en;
  logic [AW-1:0]       sb_set_addr;
  logic                dbg_req;
  logic                dbg_we;
  logic [AW-1:0]       dbg_addr;
  logic [XLEN-1:0]     dbg_wdata;
  logic                dbg_ack;
  logic [XLEN-1:0]     dbg_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_mp #(
    .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable_debug (enable_debug),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_busy      (rd_busy),
    .wr_en        (wr_en),
    .wr_dest      (wr_dest),
    .wr_data      (wr_data),
    .sb_set_en    (sb_set_en),
    .sb_set_addr  (sb_set_addr),
    .dbg_req      (dbg_req),
    .dbg_we       (dbg_we),
    .dbg_addr     (dbg_addr),
    .dbg_wdata    (dbg_wdata),
    .dbg_ack      (dbg_ack),
    .dbg_rdata    (dbg_rdata)
  );

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  d0;
    logic [31:0] x0;
    logic [4:0]  d1;
    logic [31:0] x1;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic        sb;
    logic [4:0]  sba;
    logic [31:0] e0;
    logic [31:0] e1;
    logic        b0;
    logic        b1;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic core_idle();
    wr_en       = '0;
    wr_dest     = '0;
    wr_data     = '0;
    sb_set_en   = 1'b0;
    sb_set_addr = '0;
  endtask

  task automatic set_rd(input logic [4:0] r0, input logic [4:0] r1);
    rd_addr = {r1, r0};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; enable_debug = 1'b0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    core_idle();
    set_rd(5'd0, 5'd1);

    // we, d0, x0, d1, x1, r0, r1, sb, sba, e0, e1, b0, b1
    tbl[0]  = '{2'b11, 5'd5, 32'hA5A5A5A5, 5'd5, 32'h5A5A5A5A, 5'd5, 5'd6, 1'b0, 5'd0,
                32'h5A5A5A5A, 32'h0, 1'b0, 1'b0};
    tbl[1]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0, 5'd0,
                32'h5A5A5A5A, 32'h0, 1'b0, 1'b0};
    tbl[2]  = '{2'b01, 5'd0, 32'hDEADBEEF, 5'd9, 32'hFFFFFFFF, 5'd0, 5'd9, 1'b1, 5'd0,
                32'h0, 32'h0, 1'b0, 1'b0};
    tbl[3]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd9, 1'b0, 5'd0,
                32'h0, 32'h0, 1'b0, 1'b0};
    tbl[4]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b1, 5'd7,
                32'h0, 32'h0, 1'b0, 1'b0};
    tbl[5]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 5'd5, 1'b0, 5'd0,
                32'h0, 32'h5A5A5A5A, 1'b1, 1'b0};
    tbl[6]  = '{2'b01, 5'd7, 32'h00000077, 5'd0, 32'h0, 5'd7, 5'd7, 1'b1, 5'd7,
                32'h00000077, 32'h00000077, 1'b1, 1'b1};
    tbl[7]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b0, 5'd0,
                32'h00000077, 32'h00000077, 1'b1, 1'b1};
    tbl[8]  = '{2'b10, 5'd3, 32'h33333333, 5'd7, 32'h00000777, 5'd7, 5'd3, 1'b0, 5'd0,
                32'h00000777, 32'h0, 1'b0, 1'b0};
    tbl[9]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 5'd5, 1'b0, 5'd0,
                32'h00000777, 32'h5A5A5A5A, 1'b0, 1'b0};
    tbl[10] = '{2'b11, 5'd2, 32'h00000002, 5'd4, 32'h00000004, 5'd2, 5'd4, 1'b0, 5'd0,
                32'h00000002, 32'h00000004, 1'b0, 1'b0};
    tbl[11] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd4, 5'd2, 1'b1, 5'd4,
                32'h00000004, 32'h00000002, 1'b0, 1'b0};
    tbl[12] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd4, 5'd2, 1'b0, 5'd0,
                32'h00000004, 32'h00000002, 1'b1, 1'b0};

    // Power-on reset state
    @(posedge clk); @(posedge clk);
    @(negedge clk); rst = 1'b0; set_rd(5'd5, 5'd7); #1;
    check("por_rd0", rd_data[31:0], 32'h0);
    check("por_busy", 32'(rd_busy), 32'h0);
    check("por_ack", 32'(dbg_ack), 32'h0);
    check("por_rdata", dbg_rdata, 32'h0);

    // Core write / read / scoreboard vectors
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      wr_en = tbl[k].we;
      wr_dest = {tbl[k].d1, tbl[k].d0};
      wr_data = {tbl[k].x1, tbl[k].x0};
      sb_set_en = tbl[k].sb;
      sb_set_addr = tbl[k].sba;
      set_rd(tbl[k].r0, tbl[k].r1);
      #1;
      check($sformatf("v%0d_rd0", k), rd_data[31:0], tbl[k].e0);
      check($sformatf("v%0d_rd1", k), rd_data[63:32], tbl[k].e1);
      check($sformatf("v%0d_busy0", k), 32'(rd_busy[0]), 32'(tbl[k].b0));
      check($sformatf("v%0d_busy1", k), 32'(rd_busy[1]), 32'(tbl[k].b1));
    end

    // Reset clears preloaded registers and busy bits, overriding a write
    @(negedge clk); core_idle(); sb_set_en = 1'b1; sb_set_addr = 5'd10;
    @(negedge clk); core_idle();
    set_rd(5'd10, 5'd7); #1;
    check("pre_rst_busy10", 32'(rd_busy[0]), 32'h1);
    check("pre_rst_reg7", rd_data[63:32], 32'h00000777);
    rst = 1'b1; wr_en = 2'b01; wr_dest = {5'd0, 5'd5}; wr_data = {32'h0, 32'h00001234};
    @(negedge clk); rst = 1'b0; core_idle(); set_rd(5'd5, 5'd10); #1;
    check("rst_reg5", rd_data[31:0], 32'h0);
    check("rst_busy10", 32'(rd_busy[1]), 32'h0);
    set_rd(5'd7, 5'd4); #1;
    check("rst_reg7", rd_data[31:0], 32'h0);
    check("rst_busy4", 32'(rd_busy[1]), 32'h0);
    check("rst_ack", 32'(dbg_ack), 32'h0);

    // Debug write stalled by four cycles of core writes
    @(negedge clk);
    enable_debug = 1'b1; dbg_req = 1'b1; dbg_we = 1'b1;
    dbg_addr = 5'd3; dbg_wdata = 32'h12345678;
    wr_en = 2'b01; wr_dest = {5'd0, 5'd8}; wr_data = {32'h0, 32'h00000088};
    #1; check("cont_ack_c0", 32'(dbg_ack), 32'h0);
    for (int c = 1; c < 4; c++) begin
      @(negedge clk); #1;
      check($sformatf("cont_ack_c%0d", c), 32'(dbg_ack), 32'h0);
    end
    @(negedge clk); core_idle(); set_rd(5'd3, 5'd8); #1;
    check("cont_ack_c4", 32'(dbg_ack), 32'h0);
    check("cont_reg3_early", rd_data[31:0], 32'h0);
    @(negedge clk); #1;
    check("cont_ack_c5", 32'(dbg_ack), 32'h1);
    check("cont_reg3", rd_data[31:0], 32'h12345678);
    check("cont_reg8", rd_data[63:32], 32'h00000088);
    check("cont_busy3", 32'(rd_busy[0]), 32'h0);
    dbg_req = 1'b0;
    @(negedge clk); #1;
    check("cont_ack_drop", 32'(dbg_ack), 32'h0);

    // Uncontended debug read: latency and held read data
    @(negedge clk); dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd8; #1;
    n = 0;
    while (!dbg_ack && n < 8) begin
      @(negedge clk); #1; n++;
    end
    check("dbg_rd_latency", n, 2);
    check("dbg_rd8", dbg_rdata, 32'h00000088);
    @(negedge clk); dbg_req = 1'b0;
    @(negedge clk); #1;
    check("dbg_rd_ack_drop", 32'(dbg_ack), 32'h0);
    @(negedge clk); #1;
    check("dbg_rdata_hold", dbg_rdata, 32'h00000088);

    // Abort: enable_debug falls while in ACCESS
    @(negedge clk); dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd11; dbg_wdata = 32'hCAFEF00D;
    @(negedge clk); enable_debug = 1'b0; #1;
    check("abort_ack0", 32'(dbg_ack), 32'h0);
    for (int c = 1; c < 4; c++) begin
      @(negedge clk); #1;
      check($sformatf("abort_ack%0d", c), 32'(dbg_ack), 32'h0);
    end
    dbg_req = 1'b0; set_rd(5'd11, 5'd3); #1;
    check("abort_reg11", rd_data[31:0], 32'h0);
    check("abort_reg3", rd_data[63:32], 32'h12345678);

    // Reset while in ACK; enable_debug ignored in ACK
    @(negedge clk); enable_debug = 1'b1; dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd3; #1;
    n = 0;
    while (!dbg_ack && n < 8) begin
      @(negedge clk); #1; n++;
    end
    check("ack_rd_latency", n, 2);
    check("ack_rd3", dbg_rdata, 32'h12345678);
    enable_debug = 1'b0;
    @(negedge clk); #1;
    check("ack_hold_no_enable", 32'(dbg_ack), 32'h1);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; dbg_req = 1'b0; set_rd(5'd3, 5'd8); #1;
    check("ack_rst_ack", 32'(dbg_ack), 32'h0);
    check("ack_rst_rdata", dbg_rdata, 32'h0);
    check("ack_rst_reg3", rd_data[31:0], 32'h0);
    check("ack_rst_reg8", rd_data[63:32], 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
